// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame width and line levels.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int FRAME_DATA_BITS = 8;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers are exactly log2(DEPTH) wide so they wrap without explicit compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter: byte stores to TX_ADDR are queued and sent 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] TX_ADDR      = 32'h0001_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_write,
  input  logic [7:0]  data,
  input  logic [31:0] data_address,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow
);
  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);

  tx_state_t                     state;
  logic [CW-1:0]                 baud_cnt;
  logic [2:0]                    bit_idx;
  logic [FRAME_DATA_BITS-1:0]    shreg;
  logic [FRAME_DATA_BITS-1:0]    fifo_rdata;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          fifo_empty;
  logic                          accept;
  logic                          pop;
  logic                          bit_done;
`ifdef UART_TX_PARITY_EN
  logic                          parity_bit;
`endif

  assign accept   = data_write && (data_address == TX_ADDR);
  assign bit_done = (baud_cnt == '0);
  // Popping at stop expiry lets the next start bit follow with no idle gap.
  assign pop      = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_done));
  assign busy     = (state != IDLE) | (fifo_count != '0);

  sync_fifo #(.WIDTH(FRAME_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (pop),
    .wdata (data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow <= 1'b0;
    else if (accept && fifo_full && !pop) overflow <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else if (pop) begin
      state    <= START;
      tx       <= LINE_START;
      baud_cnt <= CNT_RELOAD;
      shreg    <= fifo_rdata;
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^fifo_rdata;
`endif
    end else if (state != IDLE) begin
      if (!bit_done) begin
        baud_cnt <= baud_cnt - 1'b1;
      end else begin
        baud_cnt <= CNT_RELOAD;
        unique case (state)
          START: begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_idx <= '0;
          end
          DATA: begin
            if (bit_idx == 3'(FRAME_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= LINE_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[FRAME_DATA_BITS-1:1]};
              tx      <= shreg[1];
            end
          end
          PARITY: begin
            state <= STOP;
            tx    <= LINE_STOP;
          end
          default: begin
            state <= IDLE;
            tx    <= LINE_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: table of stores plus hand-written corner sequences,
// with a line monitor comparing decoded frames against a scoreboard queue.
module tb_mmio_uart_tx;
  localparam logic [31:0] TX_ADDR = 32'h0001_0000;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        data_write = 1'b0;
  logic [7:0]  data = '0;
  logic [31:0] data_address = '0;
  logic        tx, busy, fifo_full, overflow;

  mmio_uart_tx #(.TX_ADDR(TX_ADDR), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .data_write(data_write), .data(data),
    .data_address(data_address), .tx(tx), .busy(busy),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int frames = 0;
  int cyc = 0;
  logic [7:0] sb [$];
  int starts [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Line monitor: every cycle of a frame is compared with the level it should have.
  bit         in_frame = 1'b0;
  bit         frame_bad;
  bit         unexpected;
  int         mcyc;
  logic [NB-1:0] exp_bits;
  logic [7:0] exp_byte, rx_byte;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx === 1'b0) begin
        in_frame = 1'b1;
        mcyc = 0;
        frame_bad = 1'b0;
        rx_byte = '0;
        starts.push_back(cyc);
        unexpected = (sb.size() == 0);
        exp_byte = unexpected ? 8'h00 : sb.pop_front();
        exp_bits = '1;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = exp_byte[i];
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^exp_byte;
`endif
      end
      if (in_frame) begin
        if (tx !== exp_bits[mcyc / CPB]) frame_bad = 1'b1;
        if ((mcyc % CPB) == CPB / 2 && mcyc / CPB >= 1 && mcyc / CPB <= 8)
          rx_byte[mcyc / CPB - 1] = tx;
        mcyc++;
        if (mcyc == FRAME) begin
          in_frame = 1'b0;
          frames++;
          n_cmp++;
          if (frame_bad || unexpected || rx_byte !== exp_byte) begin
            n_fail++;
            $display("FAIL frame: actual=%02h required=%02h shape_err=%0d unexpected=%0d",
                     rx_byte, exp_byte, frame_bad, unexpected);
          end
        end
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [7:0] d, input bit acc);
    @(negedge clk);
    data_write = 1'b1;
    data_address = a;
    data = d;
    @(posedge clk);
    if (acc) sb.push_back(d);
    #1;
    data_write = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  d;
    bit          acc;
  } vec_t;
  vec_t vecs [8];

  initial begin
    int f0;
    int n;
    vecs[0] = '{TX_ADDR + 32'd1, 8'h55, 1'b0};
    vecs[1] = '{TX_ADDR - 32'd1, 8'h55, 1'b0};
    vecs[2] = '{32'h0000_0000,   8'h55, 1'b0};
    vecs[3] = '{TX_ADDR ^ 32'h8000_0000, 8'hAA, 1'b0};
    vecs[4] = '{TX_ADDR, 8'h07, 1'b1};
    vecs[5] = '{TX_ADDR, 8'h03, 1'b1};
    vecs[6] = '{TX_ADDR, 8'hFF, 1'b1};
    vecs[7] = '{TX_ADDR, 8'h00, 1'b1};

    #23;
    check("rst_tx", {31'b0, tx}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_full", {31'b0, fifo_full}, 32'h0);
    check("rst_ovf", {31'b0, overflow}, 32'h0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);

    // Single byte: start bit from the edge after the store, busy low 40 cycles later.
    f0 = frames;
    store(TX_ADDR, 8'h41, 1'b1);
    check("busy_after_store", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    check("start_at_e1", {31'b0, tx}, 32'h0);
    n = 1;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_fall_cycles", n, 32'd1 + 32'(FRAME));
    check("single_frames", frames - f0, 32'd1);

    foreach (vecs[i]) begin
      f0 = frames;
      store(vecs[i].addr, vecs[i].d, vecs[i].acc);
      check("vec_busy", {31'b0, busy}, {31'b0, vecs[i].acc});
      wait_idle(FRAME + 20);
      check("vec_frames", frames - f0, {31'b0, vecs[i].acc});
      check("vec_tx_idle", {31'b0, tx}, 32'h1);
    end

    // Back-to-back frames with no idle cycles between them.
    f0 = frames;
    starts.delete();
    store(TX_ADDR, 8'h01, 1'b1);
    store(TX_ADDR, 8'h02, 1'b1);
    store(TX_ADDR, 8'h03, 1'b1);
    wait_idle(3 * FRAME + 20);
    check("b2b_frames", frames - f0, 32'd3);
    if (starts.size() == 3) begin
      check("b2b_gap1", starts[1] - starts[0], 32'(FRAME));
      check("b2b_gap2", starts[2] - starts[1], 32'(FRAME));
    end else begin
      check("b2b_starts", starts.size(), 32'd3);
    end

    // Overflow: one byte leaves for the shifter, eight fill the FIFO, the tenth is dropped.
    f0 = frames;
    for (int i = 0; i < 10; i++) begin
      store(TX_ADDR, 8'h10 + 8'(i), i < 9);
      if (i == 7) check("full_before_9th", {31'b0, fifo_full}, 32'h0);
      if (i == 8) begin
        check("full_after_9th", {31'b0, fifo_full}, 32'h1);
        check("ovf_after_9th", {31'b0, overflow}, 32'h0);
      end
    end
    check("ovf_after_10th", {31'b0, overflow}, 32'h1);
    wait_idle(10 * FRAME + 40);
    check("ovf_frames", frames - f0, 32'd9);
    check("ovf_sb_empty", sb.size(), 32'd0);
    check("ovf_sticky", {31'b0, overflow}, 32'h1);

    // Reset in the middle of data bit 3 (0 for A5) must force the line high at once.
    store(TX_ADDR, 8'hA5, 1'b1);
    repeat (18) @(posedge clk);
    #1;
    check("pre_rst_tx_bit3", {31'b0, tx}, 32'h0);
    reset = 1'b0;
    #1;
    check("mid_rst_tx", {31'b0, tx}, 32'h1);
    check("mid_rst_busy", {31'b0, busy}, 32'h0);
    check("mid_rst_ovf", {31'b0, overflow}, 32'h0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    f0 = frames;
    store(TX_ADDR, 8'hA5, 1'b1);
    wait_idle(FRAME + 20);
    check("post_rst_frames", frames - f0, 32'd1);
    check("post_rst_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
